// File: rtl/sigma_pkg.sv
// Shared definitions for the ALU execution unit: op-codes, FSM state type,
// and a small op classification helper.
package sigma_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SLT    = 4'd5;
  localparam logic [3:0] OP_SLTU   = 4'd6;
  localparam logic [3:0] OP_SLL    = 4'd7;
  localparam logic [3:0] OP_SRL    = 4'd8;
  localparam logic [3:0] OP_SRA    = 4'd9;
  localparam logic [3:0] OP_COPY_B = 4'd10;

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } exec_state_e;

  // Shift ops are the only ones that may take the multi-cycle path.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_serial_shifter.sv
// One-bit-per-cycle shifter. A down-counter holds the remaining shift
// count; done_o flags that the current step is the final one so the parent
// can capture step_value_o on that same edge.
module serial_shifter
  import sigma_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [XLEN-1:0]    value_i,
  input  logic [SHAMT_W-1:0] amt_i,
  input  logic               left_i,
  input  logic               arith_i,
  output logic [XLEN-1:0]    step_value_o,
  output logic               done_o
);

  logic [XLEN-1:0]    value_q, value_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               left_q, left_d;
  logic               arith_q, arith_d;

  // Value after one more shift step in the latched direction/mode.
  always_comb begin
    if (left_q) begin
      step_value_o = {value_q[XLEN-2:0], 1'b0};
    end else begin
      step_value_o = {(arith_q & value_q[XLEN-1]), value_q[XLEN-1:1]};
    end
  end

  // Terminal count: the step taken while cnt_q == 1 is the last one.
  assign done_o = (cnt_q == SHAMT_W'(1));

  // Load / step / clear control for the shifter state.
  always_comb begin
    value_d = value_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    arith_d = arith_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      value_d = value_i;
      cnt_d   = amt_i;
      left_d  = left_i;
      arith_d = arith_i;
    end else if (step_i && (cnt_q != '0)) begin
      value_d = step_value_o;
      cnt_d   = cnt_q - SHAMT_W'(1);
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshake on both sides. Single-cycle
// ops complete on the accepting edge; non-zero shifts run on the serial
// shifter. The result is held until consumed or flushed.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | ready for a request
// ST_SHIFT | serial shift in progress, one bit per cycle
// ST_HOLD  | result valid, waiting for out_ready (or flush)
module alu_exec_unit
  import sigma_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op_in,
  input  logic [XLEN-1:0] operand_a_in,
  input  logic [XLEN-1:0] operand_b_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_out,
  output logic            zero_out,
  output logic            busy_out
);

  exec_state_e state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] sh_step_value;
  logic [SHAMT_W-1:0] shamt;
  logic accept;
  logic start_shift;
  logic sh_done;

  assign shamt       = operand_b_in[SHAMT_W-1:0];
  assign in_ready    = (state_q == ST_IDLE);
  assign accept      = in_valid && in_ready && !flush;
  assign start_shift = accept && is_shift_op(alu_op_in) && (shamt != '0);

  // Single-cycle result. Shift ops only reach here with a zero amount,
  // so they simply pass operand A through.
  always_comb begin
    alu_res = '0;
    case (alu_op_in)
      OP_ADD:    alu_res = operand_a_in + operand_b_in;
      OP_SUB:    alu_res = operand_a_in - operand_b_in;
      OP_AND:    alu_res = operand_a_in & operand_b_in;
      OP_OR:     alu_res = operand_a_in | operand_b_in;
      OP_XOR:    alu_res = operand_a_in ^ operand_b_in;
      OP_SLT:    alu_res = ($signed(operand_a_in) < $signed(operand_b_in)) ? XLEN'(1) : '0;
      OP_SLTU:   alu_res = (operand_a_in < operand_b_in) ? XLEN'(1) : '0;
      OP_SLL,
      OP_SRL,
      OP_SRA:    alu_res = operand_a_in;
      OP_COPY_B: alu_res = operand_b_in;
      default:   alu_res = '0;
    endcase
  end

  serial_shifter #(.XLEN(XLEN)) u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (flush),
    .load_i       (start_shift),
    .step_i       ((state_q == ST_SHIFT) && !flush),
    .value_i      (operand_a_in),
    .amt_i        (shamt),
    .left_i       (alu_op_in == OP_SLL),
    .arith_i      (alu_op_in == OP_SRA),
    .step_value_o (sh_step_value),
    .done_o       (sh_done)
  );

  // Next-state and result capture; flush wins over every other event.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start_shift) begin
          state_d = ST_SHIFT;
        end else if (accept) begin
          state_d  = ST_HOLD;
          result_d = alu_res;
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (sh_done) begin
          state_d  = ST_HOLD;
          result_d = sh_step_value;
        end
      end
      ST_HOLD: begin
        if (flush || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign out_valid  = (state_q == ST_HOLD);
  assign busy_out   = (state_q != ST_IDLE);
  assign result_out = result_q;
  assign zero_out   = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases followed by
// random operations compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      alu_op_in = 4'd0;
  logic [XLEN-1:0] operand_a_in = '0;
  logic [XLEN-1:0] operand_b_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result_out;
  logic            zero_out;
  logic            busy_out;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_res = '0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op_in    (alu_op_in),
    .operand_a_in (operand_a_in),
    .operand_b_in (operand_b_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_out   (result_out),
    .zero_out     (zero_out),
    .busy_out     (busy_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int amt;
    amt = int'(b & 32'h1F);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << amt;
      4'd8:    return a >> amt;
      4'd9:    return $unsigned($signed(a) >>> amt);
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  // Edges after the accepting edge before out_valid is seen.
  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    int amt;
    amt = int'(b & 32'h1F);
    if ((op == 4'd7 || op == 4'd8 || op == 4'd9) && amt != 0) return amt;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input string tag);
    logic [31:0] exp_r;
    int exp_lat;
    int lat;
    exp_r   = ref_result(op, a, b);
    exp_lat = ref_latency(op, b);
    in_valid     = 1'b1;
    alu_op_in    = op;
    operand_a_in = a;
    operand_b_in = b;
    out_ready    = 1'b0;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid     = 1'b0;
    alu_op_in    = 4'($urandom);
    operand_a_in = $urandom;
    operand_b_in = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".result"}, result_out, exp_r);
    chk({tag, ".zero"}, 32'(zero_out), (exp_r == 0) ? 32'd1 : 32'd0);
    chk({tag, ".in_ready_hold"}, 32'(in_ready), 32'd0);
    repeat (stall) begin
      in_valid = 1'b1;
      step();
      chk({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".stall_result"}, result_out, exp_r);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, ".consumed_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".consumed_busy"}, 32'(busy_out), 32'd0);
    chk({tag, ".retain"}, result_out, exp_r);
    last_res = exp_r;
  endtask

  initial begin
    int ov_seen;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    // Reset values while rst_n is low; requests ignored.
    in_valid = 1'b1;
    #3;
    chk("rst.result", result_out, 32'd0);
    chk("rst.zero", 32'(zero_out), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy_out), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    step();
    step();
    chk("rst.no_accept", 32'(busy_out), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    run_op(4'd0, 32'h7FFFFFFF, 32'h1, 0, "add_ovf");
    run_op(4'd1, 32'd5, 32'd5, 0, "sub_zero");
    run_op(4'd5, 32'hFFFFFFFF, 32'h1, 0, "slt");
    run_op(4'd6, 32'hFFFFFFFF, 32'h1, 0, "sltu");
    run_op(4'd9, 32'h80000000, 32'h1F, 0, "sra31");
    run_op(4'd7, 32'h1234ABCD, 32'h20, 0, "sll_amt0");
    run_op(4'd7, 32'h80000001, 32'hFFFFFFE1, 0, "sll1");
    run_op(4'd13, 32'hDEADBEEF, 32'h1, 0, "undef");
    run_op(4'd0, 32'd100, 32'd23, 5, "add_backpressure");

    // Flush three cycles into a 10-step SRL.
    ov_seen = 0;
    in_valid = 1'b1;
    alu_op_in = 4'd8;
    operand_a_in = 32'hF0F0F0F0;
    operand_b_in = 32'd10;
    step();
    in_valid = 1'b0;
    ov_seen += int'(out_valid);
    step();
    ov_seen += int'(out_valid);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_shift.busy", 32'(busy_out), 32'd0);
    chk("flush_shift.in_ready", 32'(in_ready), 32'd1);
    chk("flush_shift.retain", result_out, last_res);
    repeat (12) begin
      ov_seen += int'(out_valid);
      step();
    end
    chk("flush_shift.no_out_valid", 32'(ov_seen), 32'd0);
    run_op(4'd2, 32'hFF00FF00, 32'h0FF00FF0, 1, "and_after_flush");

    // Flush in IDLE blocks acceptance.
    flush = 1'b1;
    in_valid = 1'b1;
    alu_op_in = 4'd0;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_idle.busy", 32'(busy_out), 32'd0);

    // Flush with out_ready in HOLD: result discarded, value retained.
    in_valid = 1'b1;
    alu_op_in = 4'd4;
    operand_a_in = 32'hAAAA5555;
    operand_b_in = 32'h0000FFFF;
    step();
    in_valid = 1'b0;
    chk("flush_hold.valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    chk("flush_hold.dropped", 32'(out_valid), 32'd0);
    chk("flush_hold.retain", result_out, 32'hAAAAAAAA);
    last_res = 32'hAAAAAAAA;

    // Reset asserted mid-shift.
    in_valid = 1'b1;
    alu_op_in = 4'd9;
    operand_a_in = 32'h87654321;
    operand_b_in = 32'd20;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.result", result_out, 32'd0);
    chk("rst_mid.zero", 32'(zero_out), 32'd1);
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.busy", 32'(busy_out), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    ov_seen = 0;
    repeat (30) begin
      step();
      ov_seen += int'(out_valid);
    end
    chk("rst_mid.no_out_valid", 32'(ov_seen), 32'd0);
    last_res = 32'd0;

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = (i % 8 == 0) ? 32'h80000000 : $urandom;
      rb  = $urandom;
      if (i % 5 == 0) rb = ra;
      run_op(rop, ra, rb, $urandom_range(0, 3), $sformatf("rnd%0d_op%0d", i, rop));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port alu_op_in  input  4  ALU op-code, produced by the ALU control unit.
REQ-008 SHALL have port operand_a_in  input  XLEN  source operand A (rs1).
REQ-009 SHALL have port operand_b_in  input  XLEN  source operand B (rs2 or immediate).
REQ-010 SHALL have port out_valid  output  1  result_out/zero_out valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port result_out  output  XLEN  registered ALU result.
REQ-013 SHALL have port zero_out  output  1  result_out == 0.
REQ-014 SHALL have port busy_out  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL accept a request on a rising edge where in_valid && in_ready && !flush, capturing op and operands.
REQ-016 SHALL implement FSM states IDLE, SHIFT, HOLD; in_ready = (state == IDLE).
REQ-017 Ops: ADD a+b, SUB a-b (both modulo 2^XLEN), AND, OR, XOR, SLT signed a<b -> 1/0, SLTU unsigned a<b -> 1/0, SLL, SRL, SRA, COPY_B -> b.
REQ-018 Shift amount SHALL be operand_b_in[4:0]; upper bits of b ignored.
REQ-019 Non-shift ops and shifts with amount 0: IDLE -> HOLD on the accepting edge; out_valid high the next cycle (latency 1).
REQ-020 Shifts with amount N >= 1: IDLE -> SHIFT on accept, loading value a and counter N; one bit shifted per cycle; the edge that performs shift N goes SHIFT -> HOLD; out_valid high N cycles after accept.
REQ-021 SRA SHALL replicate bit XLEN-1 on each step; SRL and SLL SHALL fill with 0.
REQ-022 Undefined op-codes SHALL produce result 0 with latency 1.
REQ-023 HOLD: out_valid = 1; result_out/zero_out stable until out_valid && out_ready, then HOLD -> IDLE; out_valid low in IDLE and SHIFT.
REQ-024 No accept in HOLD even if out_ready is high (minimum 2 cycles per operation).
REQ-025 flush SHALL force IDLE on the next edge from any state, drop out_valid, and block acceptance that cycle; result_out retains its last value.
REQ-026 flush and out_ready in HOLD on the same edge SHALL count as consumption by neither side (result discarded).
REQ-027 zero_out SHALL be derived from the registered result.

Reset
REQ-028 While rst_n is low: state = IDLE, counter = 0, result_out = 0, zero_out = 1, out_valid = 0, busy_out = 0, in_ready = 1.
REQ-029 Reset asserted mid-SHIFT or mid-HOLD SHALL abandon the operation with no output handshake.
REQ-030 Reset deassertion SHALL take effect on the following rising edge; no request accepted while rst_n is low.

Structure
REQ-031 sigma_pkg SHALL hold the ALU op-code constants (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, COPY_B=10) and an exec-state enum typedef.
REQ-032 The iterative shifter (value register, counter, direction/arith control, done flag) SHALL be a sub-module named serial_shifter; all other logic in alu_exec_unit.

Verification
REQ-033 ADD a=0x7FFFFFFF, b=1 -> out_valid 1 cycle after accept, result 0x80000000, zero_out 0; SUB a=5, b=5 -> result 0, zero_out 1.
REQ-034 SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
REQ-035 SRA a=0x80000000, b=0x0000001F -> out_valid exactly 31 cycles after accept, result 0xFFFFFFFF; SLL b=0x20 (amount 0) -> latency 1, result = a.
REQ-036 Backpressure: ADD result held with out_ready=0 for 5 cycles -> result stable, in_ready 0; out_ready=1 -> IDLE next edge.
REQ-037 flush 3 cycles into SRL amount 10 -> IDLE next edge, out_valid never asserted; a new request is then accepted normally.
REQ-038 rst_n low during SHIFT -> all outputs at reset values immediately, no out_valid after release.
